// File: rtl/rv32i_mem_pkg.sv
// Shared types for the rv32i data-port arbiter: access widths, FSM states and the
// latched request record.
package rv32i_mem_pkg;

  // Widest byte address carried in a latched request.
  localparam int unsigned REQ_ADDR_W = 32;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2
  } width_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  // Width is kept as raw bits so the illegal encoding 3 survives latching.
  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [1:0]            width;
    logic                  sign;
    logic [31:0]           wdata;
  } req_t;

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// One requester's load/store handshake. The requester is the master; the arbiter is
// the slave.
interface rv32i_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        width;
  logic              sign;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req, we, addr, width, sign, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, width, sign, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/rv32i_mem_align.sv
// Combinational lane steering for byte/half/word accesses: byte enables, shifted
// store data, misalignment detection and extended load data.
module rv32i_mem_align
  import rv32i_mem_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  width,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [31:0] shifted;

  // Lane decode and load extension; sign=0 means sign-extend.
  always_comb begin
    be        = 4'b0000;
    rdata_ext = 32'h0;
    err       = 1'b0;
    shifted   = rdata_raw >> {offset, 3'b000};
    wdata_sh  = wdata << {offset, 3'b000};
    case (width)
      W_BYTE: begin
        be        = 4'b0001 << offset;
        rdata_ext = sign ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      W_HALF: begin
        be        = 4'b0011 << offset;
        rdata_ext = sign ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        err       = offset[0];
      end
      W_WORD: begin
        be        = 4'b1111;
        rdata_ext = shifted;
        err       = (offset != 2'b00);
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Two-port arbiter/sequencer for the rv32i RAM data port (port 0 = core, port 1 =
// loader). Each access runs IDLE -> ISSUE -> RESP.
// Define RV32I_MEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed
// priority.
module rv32i_mem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  rv32i_mem_arbiter_if.slave p0,
  rv32i_mem_arbiter_if.slave p1,
  output logic [ADDR_W-1:0] d_addr,
  output logic              d_we,
  output logic [3:0]        d_be,
  output logic [31:0]       d_wdata,
  input  logic [31:0]       d_rdata
);

  arb_state_e state_q, state_d;
  req_t       req_q, req_d;
  logic       win_q, win_d;  // 0 = port 0, 1 = port 1
  logic       pick;

`ifdef RV32I_MEM_ARB_RR_EN
  logic last_gnt_q, last_gnt_d;
`endif

  logic [ADDR_W-1:0] addr_trunc;
  logic [3:0]        be;
  logic [31:0]       wdata_sh;
  logic [31:0]       rdata_ext;
  logic              err;
  logic              issue;
  logic              resp;
  logic [31:0]       rdata_out;

  // Winner selection, evaluated only while IDLE.
  always_comb begin
`ifdef RV32I_MEM_ARB_RR_EN
    if (p0.req && p1.req) begin
      pick = ~last_gnt_q;
    end else begin
      pick = p1.req;
    end
`else
    pick = ~p0.req;
`endif
  end

  // Next-state and request latching.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    win_d   = win_q;
`ifdef RV32I_MEM_ARB_RR_EN
    last_gnt_d = last_gnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (p0.req || p1.req) begin
          state_d = ISSUE;
          win_d   = pick;
`ifdef RV32I_MEM_ARB_RR_EN
          last_gnt_d = pick;
`endif
          if (pick) begin
            req_d.we    = p1.we;
            req_d.addr  = REQ_ADDR_W'(p1.addr);
            req_d.width = p1.width;
            req_d.sign  = p1.sign;
            req_d.wdata = p1.wdata;
          end else begin
            req_d.we    = p0.we;
            req_d.addr  = REQ_ADDR_W'(p0.addr);
            req_d.width = p0.width;
            req_d.sign  = p0.sign;
            req_d.wdata = p0.wdata;
          end
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; an in-flight access is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      win_q   <= 1'b0;
`ifdef RV32I_MEM_ARB_RR_EN
      last_gnt_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      win_q   <= win_d;
`ifdef RV32I_MEM_ARB_RR_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

  assign addr_trunc = ADDR_W'(req_q.addr);

  rv32i_mem_align u_align (
    .offset    (addr_trunc[1:0]),
    .width     (req_q.width),
    .sign      (req_q.sign),
    .wdata     (req_q.wdata),
    .rdata_raw (d_rdata),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .err       (err)
  );

  // Outputs decode from registered state only; faulting accesses never touch the RAM.
  always_comb begin
    issue     = (state_q == ISSUE);
    resp      = (state_q == RESP);
    d_addr    = issue ? {addr_trunc[ADDR_W-1:2], 2'b00} : '0;
    d_we      = issue && req_q.we && !err;
    d_be      = (issue && !err) ? be : 4'b0000;
    d_wdata   = (issue && req_q.we && !err) ? wdata_sh : 32'h0;
    rdata_out = (resp && !req_q.we && !err) ? rdata_ext : 32'h0;
  end

  assign p0.gnt    = issue && !win_q;
  assign p1.gnt    = issue && win_q;
  assign p0.rvalid = resp && !win_q;
  assign p1.rvalid = resp && win_q;
  assign p0.err    = resp && !win_q && err;
  assign p1.err    = resp && win_q && err;
  assign p0.rdata  = !win_q ? rdata_out : 32'h0;
  assign p1.rdata  = win_q ? rdata_out : 32'h0;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter with a registered-read RAM model on the data port.
module tb_rv32i_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] d_addr;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;

  rv32i_mem_arbiter_if #(.ADDR_W(32)) p0_if ();
  rv32i_mem_arbiter_if #(.ADDR_W(32)) p1_if ();

  rv32i_mem_arbiter #(.ADDR_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .p0      (p0_if),
    .p1      (p1_if),
    .d_addr  (d_addr),
    .d_we    (d_we),
    .d_be    (d_be),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-enabled RAM with registered read (old data on a same-cycle write).
  logic [31:0] mem [0:63];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    d_rdata = 32'h0;
  end
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (d_we && d_be[b]) mem[d_addr[7:2]][8*b +: 8] <= d_wdata[8*b +: 8];
    end
    d_rdata <= mem[d_addr[7:2]];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input bit port, input bit req, input bit we,
                           input logic [31:0] addr, input logic [1:0] width,
                           input bit sign, input logic [31:0] wdata);
    if (!port) begin
      p0_if.req = req; p0_if.we = we; p0_if.addr = addr;
      p0_if.width = width; p0_if.sign = sign; p0_if.wdata = wdata;
    end else begin
      p1_if.req = req; p1_if.we = we; p1_if.addr = addr;
      p1_if.width = width; p1_if.sign = sign; p1_if.wdata = wdata;
    end
  endtask

  // Results of the most recent access.
  logic [31:0] r_rdata, s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        r_err, s_we;
  int          gnt_cyc, rv_cyc;

  task automatic access(input bit port, input bit we, input logic [31:0] addr,
                        input logic [1:0] width, input bit sign, input logic [31:0] wdata);
    gnt_cyc = -1; rv_cyc = -1;
    r_rdata = 32'hx; r_err = 1'bx;
    s_addr = 32'hx; s_wdata = 32'hx; s_be = 4'hx; s_we = 1'bx;
    @(negedge clk);
    drive_req(port, 1'b1, we, addr, width, sign, wdata);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (port ? p1_if.gnt : p0_if.gnt) begin
        gnt_cyc = c;
        s_addr = d_addr; s_wdata = d_wdata; s_be = d_be; s_we = d_we;
        drive_req(port, 1'b0, we, addr, width, sign, wdata);
      end
      if (port ? p1_if.rvalid : p0_if.rvalid) begin
        rv_cyc  = c;
        r_rdata = port ? p1_if.rdata : p0_if.rdata;
        r_err   = port ? p1_if.err : p0_if.err;
        break;
      end
    end
    drive_req(port, 1'b0, we, addr, width, sign, wdata);
  endtask

  int gq[$];
  int rv_seen;
  int first_gnt;

  initial begin
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    drive_req(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", {30'h0, p1_if.gnt, p0_if.gnt}, 32'h0);
    check("rst_rvalid", {30'h0, p1_if.rvalid, p0_if.rvalid}, 32'h0);
    check("rst_dbus", {27'h0, d_we, d_be}, 32'h0);
    check("rst_daddr", d_addr, 32'h0);
    check("rst_dwdata", d_wdata, 32'h0);
    reset = 1'b0;

    // Byte store then sign/zero-extended byte loads on port 0.
    access(1'b0, 1'b1, 32'h50, 2'd0, 1'b0, 32'h80);
    check("sb_be", {28'h0, s_be}, 32'h1);
    check("sb_wdata", s_wdata, 32'h80);
    check("sb_addr", s_addr, 32'h50);
    check("sb_we", {31'h0, s_we}, 32'h1);
    check("sb_rdata", r_rdata, 32'h0);
    check("sb_err", {31'h0, r_err}, 32'h0);
    access(1'b0, 1'b0, 32'h50, 2'd0, 1'b0, 32'h0);
    check("lb_sext", r_rdata, 32'hFFFF_FF80);
    access(1'b0, 1'b0, 32'h50, 2'd0, 1'b1, 32'h0);
    check("lbu_zext", r_rdata, 32'h0000_0080);

    // Port 1 byte store to lane 1, then half load sign-extended.
    access(1'b1, 1'b1, 32'h51, 2'd0, 1'b0, 32'h91);
    check("p1_sb_be", {28'h0, s_be}, 32'h2);
    check("p1_sb_wdata", s_wdata, 32'h0000_9100);
    check("p1_sb_addr", s_addr, 32'h50);
    access(1'b1, 1'b0, 32'h50, 2'd1, 1'b0, 32'h0);
    check("p1_lh_sext", r_rdata, 32'hFFFF_9180);

    // Byte store into lane 3.
    access(1'b0, 1'b1, 32'h53, 2'd0, 1'b0, 32'hA5);
    check("sb3_be", {28'h0, s_be}, 32'h8);
    check("sb3_wdata", s_wdata, 32'hA500_0000);

    // Word store/load with latency check.
    access(1'b0, 1'b1, 32'h0C, 2'd2, 1'b0, 32'h1234_5678);
    check("sw_be", {28'h0, s_be}, 32'hF);
    access(1'b0, 1'b0, 32'h0C, 2'd2, 1'b0, 32'h0);
    check("lw_rdata", r_rdata, 32'h1234_5678);
    check("lw_gnt_cyc", gnt_cyc, 32'd1);
    check("lw_rv_cyc", rv_cyc, 32'd2);

    // Upper half zero-extended, top byte sign-extended (positive).
    access(1'b1, 1'b0, 32'h0E, 2'd1, 1'b1, 32'h0);
    check("lhu_hi", r_rdata, 32'h0000_1234);
    access(1'b0, 1'b0, 32'h0F, 2'd0, 1'b0, 32'h0);
    check("lb_pos", r_rdata, 32'h0000_0012);

    // Misaligned half load.
    access(1'b0, 1'b0, 32'h51, 2'd1, 1'b0, 32'h0);
    check("mis_err", {31'h0, r_err}, 32'h1);
    check("mis_rdata", r_rdata, 32'h0);
    check("mis_bus", {27'h0, s_we, s_be}, 32'h0);

    // Illegal width store must not modify memory.
    access(1'b1, 1'b1, 32'h0C, 2'd3, 1'b0, 32'hDEAD_BEEF);
    check("ill_err", {31'h0, r_err}, 32'h1);
    check("ill_bus", {27'h0, s_we, s_be}, 32'h0);
    check("ill_rv_cyc", rv_cyc, 32'd2);
    access(1'b0, 1'b0, 32'h0C, 2'd2, 1'b0, 32'h0);
    check("ill_mem", r_rdata, 32'h1234_5678);

    // Both ports request continuously.
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, 32'h0C, 2'd2, 1'b0, 32'h0);
    drive_req(1'b1, 1'b1, 1'b0, 32'h50, 2'd2, 1'b0, 32'h0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (p0_if.gnt) gq.push_back(0);
      if (p1_if.gnt) gq.push_back(1);
    end
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    drive_req(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    repeat (4) @(negedge clk);
    check("arb_count", gq.size(), 32'd4);
    while (gq.size() < 3) gq.push_back(-1);
`ifdef RV32I_MEM_ARB_RR_EN
    check("arb_g0", gq[0], 32'd0);
    check("arb_g1", gq[1], 32'd1);
    check("arb_g2", gq[2], 32'd0);
`else
    check("arb_g0", gq[0], 32'd0);
    check("arb_g1", gq[1], 32'd0);
    check("arb_g2", gq[2], 32'd0);
`endif

    // Reset while a port 0 store is in ISSUE.
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b1, 32'h20, 2'd2, 1'b0, 32'h1111_1111);
    @(negedge clk);
    check("rst_mid_gnt", {31'h0, p0_if.gnt}, 32'h1);
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_out", {26'h0, p0_if.gnt, p0_if.rvalid, d_we, d_be != 4'h0,
                          d_addr != 32'h0, d_wdata != 32'h0}, 32'h0);
    rv_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (p0_if.rvalid || p1_if.rvalid) rv_seen++;
    end
    check("rst_mid_norv", rv_seen, 32'd0);

    drive_req(1'b0, 1'b1, 1'b0, 32'h0C, 2'd2, 1'b0, 32'h0);
    drive_req(1'b1, 1'b1, 1'b0, 32'h50, 2'd2, 1'b0, 32'h0);
    first_gnt = -1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (first_gnt < 0 && p0_if.gnt) first_gnt = 0;
      if (first_gnt < 0 && p1_if.gnt) first_gnt = 1;
      if (first_gnt >= 0) break;
    end
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    drive_req(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    check("rst_post_gnt", first_gnt, 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
